rssb_ctrl: RTL and testbench
============================

RSSB_CTRL -- requirements
Module: rssb_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data/address word width.
REQ-002 The block SHALL have parameter PC_RESET, default {1'b1, {WIDTH-1{1'b0}}} (0x80), giving the first program address, which is in the ROM half.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin or restart execution.
REQ-006 The block SHALL have port mem_out, input, WIDTH bits: combinational read data from mem_data.
REQ-007 The block SHALL have port mem_addr, output, WIDTH bits: address to mem_data.
REQ-008 The block SHALL have port mem_in, output, WIDTH bits: write data to mem_data.
REQ-009 The block SHALL have port mem_write, output, 1 bit: write strobe to mem_data.
REQ-010 The block SHALL have port busy, output, 1 bit: high in FETCH or EXEC.
REQ-011 The block SHALL have port halted, output, 1 bit: high in HALT.
REQ-012 The block SHALL have port pc_out, output, WIDTH bits: program counter.
REQ-013 The block SHALL have port acc_out, output, WIDTH bits: accumulator.

Function
REQ-014 The FSM SHALL have four states, IDLE, FETCH, EXEC and HALT, and SHALL execute exactly one state per clock, giving 2 cycles per instruction.
REQ-015 In IDLE, start=1 SHALL move the FSM to FETCH; otherwise it SHALL hold.
REQ-016 In FETCH, mem_addr SHALL equal pc and ir SHALL capture mem_out at the edge.
REQ-017 From FETCH, if mem_out==0 the FSM SHALL go to HALT with pc unchanged; otherwise it SHALL go to EXEC.
REQ-018 In EXEC, mem_addr SHALL equal ir and mem_in SHALL equal mem_out - acc, modulo 2^WIDTH.
REQ-019 borrow SHALL equal (mem_out < acc), compared unsigned.
REQ-020 At the EXEC edge, acc SHALL take mem_in and pc SHALL take pc + 1 + borrow; the FSM SHALL then go to FETCH.
REQ-021 pc[WIDTH-1] SHALL be forced to 1 after every increment, so the pc wraps within the ROM half (0xFF+1 gives 0x80; 0xFE+2 gives 0x80; 0xFF+2 gives 0x81).
REQ-022 mem_write SHALL be high only in EXEC and only when ir[WIDTH-1]==0 (RAM target); writes to ROM addresses SHALL be suppressed, while acc and pc still update.
REQ-023 Outside EXEC, mem_addr SHALL equal pc and mem_write SHALL be 0.
REQ-024 start SHALL be ignored in FETCH and EXEC.
REQ-025 In HALT, start=1 SHALL set pc to PC_RESET and acc to 0, and SHALL move the FSM to FETCH; otherwise the FSM SHALL hold.
REQ-026 busy and halted SHALL never be high together.

Reset
REQ-027 rst=0 SHALL immediately force state to IDLE, pc to PC_RESET, and acc, ir and every output register to 0, in any state including mid-EXEC.
REQ-028 Because mem_write is decoded from state, it SHALL drop combinationally when rst is asserted.
REQ-029 After rst deasserts, the first active edge SHALL evaluate IDLE.

Configuration
REQ-030 Macro RSSB_MMIO_OUT_EN, when defined, SHALL add outputs io_data (WIDTH bits) and io_valid (1 bit).
REQ-031 With RSSB_MMIO_OUT_EN, an EXEC with ir==IO_ADDR (0x7F) SHALL register io_data<=mem_in and pulse io_valid high for exactly 1 cycle after the edge; the RAM write SHALL still occur.
REQ-032 Without RSSB_MMIO_OUT_EN, those ports and that logic SHALL be absent, and address 0x7F SHALL behave as ordinary RAM.
REQ-033 With RSSB_MMIO_OUT_EN, reset SHALL clear io_data and io_valid.

Structure
REQ-034 Package rssb_pkg SHALL hold the state enum typedef, HALT_OP (0) and IO_ADDR (0x7F).
REQ-035 Sub-module rssb_alu SHALL be combinational and SHALL compute diff and borrow from mem_out and acc.
REQ-036 The FSM, pc, acc and ir SHALL live in rssb_ctrl.

Verification
REQ-037 Reset: rst=0 mid-EXEC -> immediately state=IDLE, pc_out=0x80, acc_out=0, mem_write=0, busy=0, halted=0.
REQ-038 No borrow: ROM[0x80]=0x10, RAM[0x10]=0x05, acc=0, pulse start -> EXEC cycle shows mem_addr=0x10, mem_in=0x05, mem_write=1; afterwards acc=0x05, pc=0x81, RAM[0x10]=0x05.
REQ-039 Borrow/skip: ROM[0x81]=0x11, RAM[0x11]=0x03, acc=0x05 -> mem_in=0xFE, acc=0xFE, pc=0x83.
REQ-040 ROM target and halt: ROM[0x83]=0x90 -> mem_write=0, acc updated; ROM[0x84]=0x00 -> halted=1, busy=0, pc=0x84; start -> pc=0x80, acc=0, FETCH.
REQ-041 Wrap: pc=0xFE, borrow=1 -> pc=0x80; pc=0xFF, borrow=0 -> pc=0x80.
REQ-042 MMIO, built with RSSB_MMIO_OUT_EN: ir=0x7F, RAM[0x7F]=0x20, acc=0x01 -> io_data=0x1F, io_valid high 1 cycle, RAM[0x7F]=0x1F.
REQ-043 MMIO, built without RSSB_MMIO_OUT_EN: the same program SHALL give only RAM[0x7F]=0x1F.

Source files
------------

// File: rtl/rssb_pkg.sv
// rssb_pkg: shared types and constants for the RSSB (reverse-subtract-skip-
// if-borrow) controller.
//   state_e  - controller FSM states
//   HALT_OP  - instruction word that stops execution
//   IO_ADDR  - RAM address mirrored to the MMIO output port when the
//              RSSB_MMIO_OUT_EN build option is enabled
package rssb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam int HALT_OP = 0;
    localparam int IO_ADDR = 'h7F;

endpackage

// File: rtl/rssb_alu.sv
// rssb_alu: combinational subtract unit for the RSSB instruction.
//   mem_out - operand read from memory
//   acc     - accumulator
//   diff    - mem_out - acc, modulo 2^WIDTH
//   borrow  - 1 when mem_out < acc (unsigned); selects the skip
module rssb_alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] mem_out,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    assign diff   = mem_out - acc;
    assign borrow = (mem_out < acc);

endmodule

// File: rtl/rssb_ctrl.sv
// rssb_ctrl: single-instruction (RSSB) processor controller, 2 clocks per
// instruction (FETCH then EXEC). Memory is external with combinational read.
//   clk, rst          - clock (rising edge), asynchronous active-low reset
//   start             - begin from IDLE, or restart from HALT
//   mem_out           - read data from memory at mem_addr
//   mem_addr          - pc in every state except EXEC, where it is ir
//   mem_in, mem_write - write data / strobe (EXEC with a RAM target only)
//   busy, halted      - FETCH/EXEC, HALT
//   pc_out, acc_out   - architectural registers
// Build option RSSB_MMIO_OUT_EN adds io_data/io_valid: a store to IO_ADDR is
// also captured on io_data with a one-cycle io_valid pulse.
module rssb_ctrl
    import rssb_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] PC_RESET = {1'b1, {(WIDTH-1){1'b0}}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mem_out,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_in,
    output logic             mem_write,
    output logic             busy,
    output logic             halted,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] acc_out
`ifdef RSSB_MMIO_OUT_EN
    ,
    output logic [WIDTH-1:0] io_data,
    output logic             io_valid
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ir_q, ir_d;

    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] pc_sum;
    logic [WIDTH-1:0] pc_next;

    rssb_alu #(.WIDTH(WIDTH)) u_alu (
        .mem_out (mem_out),
        .acc     (acc_q),
        .diff    (diff),
        .borrow  (borrow)
    );

    // Skip-on-borrow increment; the top bit is pinned so pc never leaves ROM.
    assign pc_sum  = pc_q + {{(WIDTH-1){1'b0}}, 1'b1} + {{(WIDTH-1){1'b0}}, borrow};
    assign pc_next = {1'b1, pc_sum[WIDTH-2:0]};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = mem_out;
                state_d = (mem_out == WIDTH'(HALT_OP)) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                acc_d   = diff;
                pc_d    = pc_next;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    pc_d    = PC_RESET;
                    acc_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory-side outputs decode from state_q so they fall with reset.
    assign mem_addr  = (state_q == ST_EXEC) ? ir_q : pc_q;
    assign mem_in    = diff;
    assign mem_write = (state_q == ST_EXEC) && !ir_q[WIDTH-1];
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted    = (state_q == ST_HALT);
    assign pc_out    = pc_q;
    assign acc_out   = acc_q;

`ifdef RSSB_MMIO_OUT_EN
    logic [WIDTH-1:0] io_data_q, io_data_d;
    logic             io_valid_q, io_valid_d;

    always_comb begin
        io_valid_d = (state_q == ST_EXEC) && (ir_q == WIDTH'(IO_ADDR));
        io_data_d  = io_valid_d ? diff : io_data_q;
    end

    assign io_data  = io_data_q;
    assign io_valid = io_valid_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_RESET;
            acc_q   <= '0;
            ir_q    <= '0;
`ifdef RSSB_MMIO_OUT_EN
            io_data_q  <= '0;
            io_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ir_q    <= ir_d;
`ifdef RSSB_MMIO_OUT_EN
            io_data_q  <= io_data_d;
            io_valid_q <= io_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_rssb_ctrl.sv
// tb_rssb_ctrl: directed bench for rssb_ctrl with a 256-byte memory model.
// Works in both builds; MMIO port checks exist only with RSSB_MMIO_OUT_EN.
module tb_rssb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] mem_out, mem_addr, mem_in, pc_out, acc_out;
    logic       mem_write, busy, halted;
`ifdef RSSB_MMIO_OUT_EN
    logic [7:0] io_data;
    logic       io_valid;
`endif

    // Memory model; the load port only runs while the DUT is held in reset.
    logic [7:0] mem [256];
    logic       ld_en, ld_clr;
    logic [7:0] ld_addr, ld_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rssb_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_out   (mem_out),
        .mem_addr  (mem_addr),
        .mem_in    (mem_in),
        .mem_write (mem_write),
        .busy      (busy),
        .halted    (halted),
        .pc_out    (pc_out),
        .acc_out   (acc_out)
`ifdef RSSB_MMIO_OUT_EN
        ,
        .io_data   (io_data),
        .io_valid  (io_valid)
`endif
    );

    assign mem_out = mem[mem_addr];

    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_in;
        end
    end

    typedef struct {
        logic       start;
        logic       busy;
        logic       halted;
        logic       we;
        logic       chk_in;
        logic [7:0] pc;
        logic [7:0] acc;
        logic [7:0] addr;
        logic [7:0] din;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // All tasks below are entered and left on a falling edge.
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic clear_mem();
        rst    = 1'b0;
        ld_clr = 1'b1;
        @(negedge clk);
        ld_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_pc(input logic [7:0] target, output logic found);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (pc_out == target) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        //            start busy halt we  chk  pc     acc    addr   din
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h80, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h80, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 8'h00, 8'h10, 8'h05};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 8'h05, 8'h81, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 8'h05, 8'h11, 8'hFE};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h83, 8'hFE, 8'h83, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h83, 8'hFE, 8'h90, 8'h01};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h84, 8'h01, 8'h84, 8'h00};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h84, 8'h01, 8'h84, 8'h00};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h80, 8'h00};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 8'h00, 8'h10, 8'h05};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 8'h05, 8'h81, 8'h00};

        rst = 1'b0; start = 1'b0; ld_en = 1'b0; ld_clr = 1'b0;
        ld_addr = 8'h00; ld_data = 8'h00;
        @(negedge clk);

        // Main program: no-borrow, borrow/skip, ROM-target, halt.
        clear_mem();
        poke(8'h80, 8'h10); poke(8'h10, 8'h05);
        poke(8'h81, 8'h11); poke(8'h11, 8'h03);
        poke(8'h83, 8'h90); poke(8'h90, 8'hFF);

        check("rst_pc",     pc_out,    8'h80);
        check("rst_acc",    acc_out,   8'h00);
        check("rst_busy",   busy,      1'b0);
        check("rst_halted", halted,    1'b0);
        check("rst_we",     mem_write, 1'b0);
`ifdef RSSB_MMIO_OUT_EN
        check("rst_io_valid", io_valid, 1'b0);
        check("rst_io_data",  io_data,  8'h00);
`endif
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start;
            check($sformatf("row%0d_busy", i),   busy,      vecs[i].busy);
            check($sformatf("row%0d_halted", i), halted,    vecs[i].halted);
            check($sformatf("row%0d_we", i),     mem_write, vecs[i].we);
            check($sformatf("row%0d_pc", i),     pc_out,    vecs[i].pc);
            check($sformatf("row%0d_acc", i),    acc_out,   vecs[i].acc);
            check($sformatf("row%0d_addr", i),   mem_addr,  vecs[i].addr);
            if (vecs[i].chk_in) check($sformatf("row%0d_din", i), mem_in, vecs[i].din);
            @(negedge clk);
        end
        start = 1'b0;
        check("ram10", mem[8'h10], 8'h05);
        check("ram11", mem[8'h11], 8'hFE);
        check("rom90_kept", mem[8'h90], 8'hFF);

        // Now in EXEC at 0x11: asynchronous reset must act without a clock edge.
        check("midexec_we_before", mem_write, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("midexec_pc",     pc_out,    8'h80);
        check("midexec_acc",    acc_out,   8'h00);
        check("midexec_we",     mem_write, 1'b0);
        check("midexec_busy",   busy,      1'b0);
        check("midexec_halted", halted,    1'b0);
        check("midexec_addr",   mem_addr,  8'h80);
        @(negedge clk);

        // Wrap A: 0xFE with borrow lands on 0x80.
        clear_mem();
        for (int a = 8'h80; a <= 8'hFC; a++) poke(8'(a), 8'h20);
        poke(8'hFD, 8'h22); poke(8'h22, 8'h05); poke(8'hFE, 8'h21);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle_busy", busy, 1'b0);
        pulse_start();
        wait_pc(8'hFE, found);
        check("wrapA_reached", found, 1'b1);
        @(negedge clk);
        check("wrapA_din", mem_in, 8'hFB);
        @(negedge clk);
        check("wrapA_pc",  pc_out,  8'h80);
        check("wrapA_acc", acc_out, 8'hFB);

        // Wrap B: 0xFF without borrow lands on 0x80.
        clear_mem();
        for (int a = 8'h80; a <= 8'hFF; a++) poke(8'(a), 8'h20);
        rst = 1'b1;
        pulse_start();
        wait_pc(8'hFF, found);
        check("wrapB_reached", found, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("wrapB_pc", pc_out, 8'h80);

        // Store to 0x7F: acc=1 then RAM[0x7F]=0x20 -> 0x1F.
        clear_mem();
        poke(8'h80, 8'h30); poke(8'h30, 8'h01);
        poke(8'h81, 8'h7F); poke(8'h7F, 8'h20);
        rst = 1'b1;
        pulse_start();          // now FETCH 0x80
        @(negedge clk);         // EXEC 0x30
        @(negedge clk);         // FETCH 0x81
        @(negedge clk);         // EXEC 0x7F
        check("io_exec_addr", mem_addr,  8'h7F);
        check("io_exec_din",  mem_in,    8'h1F);
        check("io_exec_we",   mem_write, 1'b1);
`ifdef RSSB_MMIO_OUT_EN
        check("io_valid_pre", io_valid, 1'b0);
`endif
        @(negedge clk);         // FETCH 0x82
`ifdef RSSB_MMIO_OUT_EN
        check("io_valid_pulse", io_valid, 1'b1);
        check("io_data_val",    io_data,  8'h1F);
`endif
        @(negedge clk);         // HALT
        check("io_halted", halted, 1'b1);
`ifdef RSSB_MMIO_OUT_EN
        check("io_valid_drop", io_valid, 1'b0);
        check("io_data_hold",  io_data,  8'h1F);
`endif
        check("ram7f", mem[8'h7F], 8'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
